// File: rtl/clk_edge_detector.sv
// rtl/clk_edge_detector.sv - clock phase indicators derived from rising/falling edge toggle flops
// Reports which clk phase follows the most recent qualifying edge since reset release.
module clk_edge_detector (
    input  logic clk,
    input  logic rst,
    output logic posedge_clk,
    output logic negedge_clk,
    output logic dual_edge_clk
);

    logic r_p_tog;
    logic r_p_seen;
    logic r_n_tog;
    logic r_n_seen;
    logic r_fall_first;
    logic w_pos_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_tog  <= 1'b0;
            r_p_seen <= 1'b0;
        end else begin
            r_p_tog  <= ~r_p_tog;
            r_p_seen <= 1'b1;
        end
    end

    // Parity of the toggle pair alone is ambiguous once both edges have been
    // seen; r_fall_first records which edge type armed the detector first.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_n_tog      <= 1'b0;
            r_n_seen     <= 1'b0;
            r_fall_first <= 1'b0;
        end else begin
            r_n_tog  <= ~r_n_tog;
            r_n_seen <= 1'b1;
            if (!r_n_seen) begin
                r_fall_first <= ~r_p_seen;
            end
        end
    end

    assign w_pos_phase   = r_p_tog ^ r_n_tog ^ r_fall_first;
    assign posedge_clk   = r_p_seen & w_pos_phase;
    assign negedge_clk   = r_n_seen & ~w_pos_phase;
    assign dual_edge_clk = posedge_clk | negedge_clk;

endmodule

// File: tb/tb_clk_edge_detector.sv
// tb/tb_clk_edge_detector.sv - directed and randomized bench for clk_edge_detector
module tb_clk_edge_detector;

    logic clk;
    logic rst;
    logic posedge_clk;
    logic negedge_clk;
    logic dual_edge_clk;

    int n_total;
    int n_pass;
    // Most recent qualifying edge since reset: 0 none, 1 rising, 2 falling
    int last_edge;

    clk_edge_detector dut (
        .clk           (clk),
        .rst           (rst),
        .posedge_clk   (posedge_clk),
        .negedge_clk   (negedge_clk),
        .dual_edge_clk (dual_edge_clk)
    );

    task automatic cmp(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check(input string tag);
        cmp({tag, "_pos"}, posedge_clk, last_edge == 1);
        cmp({tag, "_neg"}, negedge_clk, last_edge == 2);
        cmp({tag, "_dual"}, dual_edge_clk, last_edge != 0);
        cmp({tag, "_excl"}, posedge_clk & negedge_clk, 1'b0);
    endtask

    task automatic half_cycle(input string tag);
        clk = ~clk;
        if (rst) last_edge = clk ? 1 : 2;
        #1;
        check(tag);
        #4;
    endtask

    task automatic set_rst(input logic v, input string tag);
        #2;
        rst = v;
        if (!v) last_edge = 0;
        #1;
        check(tag);
        #2;
    endtask

    task automatic stall(input int ns, input string tag);
        for (int i = 0; i < ns / 5; i++) begin
            #5;
            check(tag);
        end
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        last_edge = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("rst_init");

        for (int i = 0; i < 20; i++) half_cycle("rst_hold");

        // Release with clk high: first qualifying edge is falling
        if (!clk) half_cycle("pre_rel1");
        set_rst(1'b1, "rel_clk1");
        half_cycle("rel1_fall");
        half_cycle("rel1_rise");

        for (int i = 0; i < 40; i++) begin
            half_cycle("free_run");
            cmp("free_pos_clk", posedge_clk, clk);
            cmp("free_neg_nclk", negedge_clk, ~clk);
        end

        // Reset pulse of 20ns starting while clk is high
        if (!clk) half_cycle("pre_pulse");
        set_rst(1'b0, "pulse_assert");
        half_cycle("pulse_in");
        half_cycle("pulse_in");
        half_cycle("pulse_in");
        set_rst(1'b1, "pulse_release");
        half_cycle("pulse_rearm");
        half_cycle("pulse_rearm");

        // Release with clk low: first qualifying edge is rising
        if (clk) half_cycle("pre_rel0");
        set_rst(1'b0, "rel0_assert");
        half_cycle("rel0_in");
        half_cycle("rel0_in");
        set_rst(1'b1, "rel_clk0");
        half_cycle("rel0_rise");
        half_cycle("rel0_fall");

        // Clock held high after a rise
        if (clk) half_cycle("pre_stop");
        half_cycle("stop_rise");
        stall(50, "stop_hold");
        half_cycle("stop_resume");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                int n;
                n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++) half_cycle("rnd_run");
            end else if (r < 8) begin
                int n;
                n = $urandom_range(0, 4);
                set_rst(1'b0, "rnd_rst_on");
                for (int k = 0; k < n; k++) half_cycle("rnd_rst_in");
                set_rst(1'b1, "rnd_rst_off");
            end else begin
                stall($urandom_range(1, 6) * 5, "rnd_stall");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
